// File: rtl/cpu_pkg.sv
// Shared constants and types for the PLP execute stage.
// ALU control/function codes and the multiply/divide state encoding.
package cpu_pkg;

    localparam logic [5:0] ALUC_RTYPE = 6'h00;
    localparam logic [5:0] ALUC_ADDI  = 6'h08;
    localparam logic [5:0] ALUC_ADDIU = 6'h09;
    localparam logic [5:0] ALUC_SLTI  = 6'h0a;
    localparam logic [5:0] ALUC_SLTIU = 6'h0b;
    localparam logic [5:0] ALUC_ANDI  = 6'h0c;
    localparam logic [5:0] ALUC_ORI   = 6'h0d;
    localparam logic [5:0] ALUC_LUI   = 6'h0f;
    localparam logic [5:0] ALUC_LW    = 6'h23;
    localparam logic [5:0] ALUC_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    // The low two function bits select the MD operation directly:
    // bit 1 = divide, bit 0 = unsigned.
    function automatic logic is_md_fn(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/cpu_ex_md_if.sv
// ID-to-EX instruction bundle and EX/MEM pipeline register outputs.
// The slave modport is the execute stage; master is the ID/MEM side.
interface cpu_ex_md_if #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) ();
    logic            id_valid;
    logic            id_c_rfw;
    logic            id_c_drw;
    logic [1:0]      id_c_wbsource;
    logic [5:0]      id_c_alucontrol;
    logic [5:0]      id_func;
    logic [SHW-1:0]  id_shamt;
    logic [XLEN-1:0] id_rfa;
    logic [XLEN-1:0] id_rfb;
    logic [XLEN-1:0] id_rfbse;
    logic [4:0]      id_rf_waddr;
    logic [XLEN-1:0] id_jalra;

    logic            ex_stall;

    logic            p_valid;
    logic            p_c_rfw;
    logic            p_c_drw;
    logic [1:0]      p_c_wbsource;
    logic [XLEN-1:0] p_alu_r;
    logic [XLEN-1:0] p_rfb;
    logic [XLEN-1:0] p_jalra;
    logic [4:0]      p_rf_waddr;

    modport master (
        output id_valid, id_c_rfw, id_c_drw, id_c_wbsource, id_c_alucontrol,
               id_func, id_shamt, id_rfa, id_rfb, id_rfbse, id_rf_waddr, id_jalra,
        input  ex_stall, p_valid, p_c_rfw, p_c_drw, p_c_wbsource, p_alu_r,
               p_rfb, p_jalra, p_rf_waddr
    );

    modport slave (
        input  id_valid, id_c_rfw, id_c_drw, id_c_wbsource, id_c_alucontrol,
               id_func, id_shamt, id_rfa, id_rfb, id_rfbse, id_rf_waddr, id_jalra,
        output ex_stall, p_valid, p_c_rfw, p_c_drw, p_c_wbsource, p_alu_r,
               p_rfb, p_jalra, p_rf_waddr
    );
endinterface

// File: rtl/cpu_muldiv.sv
// Iterative multiply/divide unit with HI/LO: one bit per cycle on operand
// magnitudes (shift-add / restoring divide), sign fixed in the last step.
module cpu_muldiv
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN + 1);

    md_state_t       state_reg, state_next;
    logic [CW-1:0]   count_reg;
    logic            is_mul_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic [XLEN-1:0] opnd_reg;
    logic [XLEN-1:0] acc_hi_reg;
    logic [XLEN-1:0] acc_lo_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;

    logic            op_signed, op_mul, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        op_signed = ~op[0];
        op_mul    = ~op[1];
        sign_a    = op_signed & a[XLEN-1];
        sign_b    = op_signed & b[XLEN-1];
        mag_a     = sign_a ? -a : a;
        mag_b     = sign_b ? -b : b;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   hi_fix, lo_fix;

    // Multiply keeps the partial product in {acc_hi, acc_lo} with the
    // multiplier draining out of acc_lo; divide keeps the remainder in acc_hi
    // and shifts quotient bits into acc_lo as the dividend shifts out.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
        div_ge    = ~div_diff[XLEN+1];
        if (is_mul_reg) begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
        end else begin
            hi_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_step = {acc_lo_reg[XLEN-2:0], div_ge};
        end
        prod_mag = {hi_step, lo_step};
        prod_fix = neg_q_reg ? -prod_mag : prod_mag;
        if (is_mul_reg) begin
            hi_fix = prod_fix[2*XLEN-1:XLEN];
            lo_fix = prod_fix[XLEN-1:0];
        end else begin
            hi_fix = neg_r_reg ? -hi_step : hi_step;
            lo_fix = neg_q_reg ? -lo_step : lo_step;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: if (start) state_next = MD_BUSY;
            MD_BUSY: if (count_reg == CW'(1)) state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= MD_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            is_mul_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            opnd_reg   <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (start) begin
                        count_reg  <= CW'(XLEN);
                        is_mul_reg <= op_mul;
                        // A zero divisor yields an all-ones quotient regardless of sign.
                        neg_q_reg  <= op_mul ? (sign_a ^ sign_b)
                                             : ((sign_a ^ sign_b) & (b != '0));
                        neg_r_reg  <= sign_a;
                        opnd_reg   <= op_mul ? mag_a : mag_b;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= op_mul ? mag_b : mag_a;
                    end
                end
                MD_BUSY: begin
                    count_reg  <= count_reg - CW'(1);
                    acc_hi_reg <= hi_step;
                    acc_lo_reg <= lo_step;
                    if (count_reg == CW'(1)) begin
                        hi_reg <= hi_fix;
                        lo_reg <= lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == MD_BUSY);
    assign done = (state_reg == MD_DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: rtl/cpu_ex_md.sv
// PLP execute stage: single-cycle ALU and shifter, iterative MD unit with
// HI/LO, and the EX/MEM pipeline register with stall-bubble insertion.
module cpu_ex_md
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst,
    cpu_ex_md_if.slave   bus
);
    logic [XLEN-1:0] x, y, alu_r;
    logic [SHW-1:0]  sh_imm, sh_var;
    logic            is_md, md_start, md_busy, md_done, ex_stall;
    logic [XLEN-1:0] md_hi, md_lo;

    assign x      = bus.id_rfa;
    assign y      = bus.id_rfbse;
    assign sh_imm = bus.id_shamt;
    assign sh_var = x[SHW-1:0];

    assign is_md    = (bus.id_c_alucontrol == ALUC_RTYPE) && is_md_fn(bus.id_func);
    assign md_start = bus.id_valid && is_md;
    // While neither busy nor done the unit is idle and about to accept the op.
    assign ex_stall = md_busy | (md_start & ~md_done);

    cpu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (bus.id_func[1:0]),
        .a     (bus.id_rfa),
        .b     (bus.id_rfb),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_comb begin
        alu_r = '0;
        case (bus.id_c_alucontrol)
            ALUC_ADDI, ALUC_ADDIU, ALUC_LW, ALUC_SW: alu_r = x + y;
            ALUC_ANDI:  alu_r = x & y;
            ALUC_ORI:   alu_r = x | y;
            ALUC_SLTI:  alu_r = XLEN'($signed(x) < $signed(y));
            ALUC_SLTIU: alu_r = XLEN'(x < y);
            ALUC_LUI:   alu_r = y << (XLEN / 2);
            ALUC_RTYPE: begin
                case (bus.id_func)
                    FN_ADDU: alu_r = x + y;
                    FN_SUBU: alu_r = x - y;
                    FN_AND:  alu_r = x & y;
                    FN_OR:   alu_r = x | y;
                    FN_NOR:  alu_r = ~(x | y);
                    FN_SLT:  alu_r = XLEN'($signed(x) < $signed(y));
                    FN_SLTU: alu_r = XLEN'(x < y);
                    FN_SLL:  alu_r = y << sh_imm;
                    FN_SRL:  alu_r = y >> sh_imm;
                    FN_SRA:  alu_r = $unsigned($signed(y) >>> sh_imm);
                    FN_SLLV: alu_r = y << sh_var;
                    FN_SRLV: alu_r = y >> sh_var;
                    FN_SRAV: alu_r = $unsigned($signed(y) >>> sh_var);
                    FN_MFHI: alu_r = md_hi;
                    FN_MFLO: alu_r = md_lo;
                    default: alu_r = '0;
                endcase
            end
            default: alu_r = '0;
        endcase
    end

    logic            p_valid_reg, p_c_rfw_reg, p_c_drw_reg;
    logic [1:0]      p_c_wbsource_reg;
    logic [XLEN-1:0] p_alu_r_reg, p_rfb_reg, p_jalra_reg;
    logic [4:0]      p_rf_waddr_reg;
    logic            load;

    assign load = bus.id_valid & ~ex_stall;

    // Stalls and ID bubbles both clear every field, not just the write enables.
    always_ff @(posedge clk) begin
        if (rst || !load) begin
            p_valid_reg      <= 1'b0;
            p_c_rfw_reg      <= 1'b0;
            p_c_drw_reg      <= 1'b0;
            p_c_wbsource_reg <= '0;
            p_alu_r_reg      <= '0;
            p_rfb_reg        <= '0;
            p_jalra_reg      <= '0;
            p_rf_waddr_reg   <= '0;
        end else begin
            p_valid_reg      <= 1'b1;
            p_c_rfw_reg      <= bus.id_c_rfw;
            p_c_drw_reg      <= bus.id_c_drw;
            p_c_wbsource_reg <= bus.id_c_wbsource;
            p_alu_r_reg      <= alu_r;
            p_rfb_reg        <= bus.id_rfb;
            p_jalra_reg      <= bus.id_jalra;
            p_rf_waddr_reg   <= bus.id_rf_waddr;
        end
    end

    assign bus.ex_stall     = ex_stall;
    assign bus.p_valid      = p_valid_reg;
    assign bus.p_c_rfw      = p_c_rfw_reg;
    assign bus.p_c_drw      = p_c_drw_reg;
    assign bus.p_c_wbsource = p_c_wbsource_reg;
    assign bus.p_alu_r      = p_alu_r_reg;
    assign bus.p_rfb        = p_rfb_reg;
    assign bus.p_jalra      = p_jalra_reg;
    assign bus.p_rf_waddr   = p_rf_waddr_reg;

endmodule

// File: doc/cpu_ex_md.md
# cpu_ex_md

Parametrised execute stage for the PLP pipeline: the single-cycle ALU of the current EX stage plus variable shifts, an arithmetic right shift, and an iterative multiply/divide unit with HI/LO registers. It sits between ID and MEM. It raises a stall to ID while a multi-cycle multiply or divide is in flight, and inserts a bubble into the EX/MEM register while stalled.

## Interface
- XLEN, 32: datapath width; at least 8.
- SHW, $clog2(XLEN): shift-amount width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID presents a real instruction (0 = bubble).
- id_c_rfw, id_c_drw  in  1 each  register-file / data-memory write enables.
- id_c_wbsource  in  2  writeback source select, passed through.
- id_c_alucontrol  in  6  opcode-derived ALU control (0x00 = R-type, use id_func).
- id_func  in  6  R-type function code.
- id_shamt  in  SHW  immediate shift amount.
- id_rfa, id_rfb, id_rfbse  in  XLEN each  rs, rt, and rt-or-sign-extended immediate.
- id_rf_waddr  in  5  destination register.
- id_jalra  in  XLEN  link address, passed through.
- ex_stall  out  1  ID must hold its outputs and PC this cycle.
- p_valid, p_c_rfw, p_c_drw  out  1 each  registered; reset 0.
- p_c_wbsource  out  2  registered; reset 0.
- p_alu_r, p_rfb, p_jalra  out  XLEN each  registered; reset 0.
- p_rf_waddr  out  5  registered; reset 0.

## Operation
- ALU control mapping:
  - 0x08, 0x09, 0x23, 0x2b → addu.
  - 0x0c → and; 0x0d → or; 0x0a → slt; 0x0b → sltu.
  - 0x0f (lui) → sll by XLEN/2.
  - 0x00 → id_func.
  - Any other value → result 0.
- Functions, with x = id_rfa and y = id_rfbse:
  - 0x21 addu; 0x23 subu; 0x24 and; 0x25 or; 0x27 nor.
  - 0x2a slt (signed, result 0/1); 0x2b sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra: shift y by id_shamt.
  - 0x04 sllv, 0x06 srlv, 0x07 srav: shift y by x[SHW-1:0].
  - 0x10 mfhi, 0x12 mflo.
  - 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu.
  - Unknown function → 0.
- All arithmetic is modulo 2^XLEN; there are no overflow traps.
- MD operations use x = id_rfa and y = id_rfb.
  - mult/multu: {HI,LO} = full 2·XLEN product.
  - div/divu: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: LO = all-ones, HI = dividend. No stall difference.
  - Signed overflow (−2^(XLEN−1) / −1): LO = −2^(XLEN−1), HI = 0.
- Implementation method: shift-add multiply and restoring divide on magnitudes, one bit per cycle, with a sign fix-up in the final state.
- MD state machine:
  - IDLE: if id_valid and the op is an MD op → latch operands, signs and opcode; count = XLEN; go to BUSY; ex_stall = 1.
  - BUSY: one iteration per cycle, count decrements. When count reaches 0, write HI/LO (sign-corrected) and go to DONE. ex_stall = 1.
  - DONE: ex_stall = 0; the held MD instruction passes into the pipeline register with its own controls; go to IDLE.
- mfhi/mflo in IDLE read the current HI/LO. HI/LO write in the cycle BUSY→DONE, so back-to-back mult then mflo returns the new value.
- While ex_stall = 1, the pipeline register loads a bubble: p_valid = 0, p_c_rfw = 0, p_c_drw = 0, other fields 0.
- If id_valid = 0, the pipeline register loads a bubble and the FSM stays IDLE.

## Timing
- Non-MD ops: 1 cycle; the result appears in the p_* registers at the next clk edge.
- MD op: ex_stall is high for exactly XLEN+1 consecutive cycles, starting combinationally in the cycle the op is presented. The op reaches p_* XLEN+2 edges after first presentation.
- ex_stall is combinational: (state==IDLE and id_valid and MD op) or state==BUSY.
- rst in any state:
  - State returns to IDLE.
  - HI, LO and all p_* outputs are set to 0.
  - ex_stall is 0 in the cycle after the rst edge, even if an MD op was mid-flight; the partial result is discarded.
- HI/LO are only changed by MD ops and rst.

## Structure
- Shared package cpu_pkg holds:
  - ALU control and function-code localparams (ALUC_*, FN_*).
  - The MD state enum (MD_IDLE, MD_BUSY, MD_DONE).
- Natural sub-module: cpu_muldiv (parameter XLEN).
  - Contains the FSM, counter, accumulators and HI/LO.
  - Ports: start, op[1:0], a, b, busy, done, hi, lo.
- The combinational ALU and pipeline register remain in cpu_ex_md.

## Test plan
- XLEN=32: addu 0x7fffffff+1 → p_alu_r 0x80000000. slt −1,1 → 1. sltu −1,1 → 0. lui 0x1234 → 0x12340000. srav y=0x80000000, x=4 → 0xf8000000.
- mult −3×5, then mfhi/mflo: ex_stall high for exactly 33 cycles; mflo → 0xfffffff1, mfhi → 0xffffffff. multu 0xffffffff×2 → HI 1, LO 0xfffffffe.
- div −7/2 → LO 0xfffffffd, HI 0xffffffff. divu 7/0 → LO 0xffffffff, HI 7. div 0x80000000/−1 → LO 0x80000000, HI 0.
- Stall bubble: sw issued during BUSY is held by ID; p_c_drw stays 0 until DONE; sw then executes once. Issuing mult then immediate mflo returns the new LO.
- rst asserted at BUSY count=10 → next cycle ex_stall 0, HI=LO=0, all p_* 0; a subsequent mult completes normally in 34 cycles.
- Parameter sweep XLEN=16: mult 0x7fff×0x7fff → HI 0x3fff, LO 0x0001; stall length 17; random ALU ops checked against a reference model (10k vectors).
